// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe
//   N-source, WIDTH-bit operand selector feeding a 2-entry skid buffer with
//   valid/ready handshakes on both sides. Out-of-range selects capture zero
//   and set a sticky error flag.
//
//   Optional feature: define OPSEL_XFER_COUNT_EN to build a 16-bit wrapping
//   counter of delivered operands on xfer_count. When undefined, xfer_count
//   is tied to zero and no counter flops exist.
//
// Ports
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     upstream handshake (sel, src_data)
//   sel [SEL_W]           source index of the offered beat
//   src_data [NUM_SRC*W]  flattened sources, source i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready   downstream (ALU) handshake
//   out_data [WIDTH]      selected operand
//   out_sel [SEL_W]       select tag that produced out_data
//   err_sel               sticky out-of-range flag, err_clr clears it
//   xfer_count [16]       delivered-operand count (0 without the feature)
module operand_sel_pipe #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     err_sel,
    input  logic                     err_clr,
    output logic [15:0]              xfer_count
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           state;
    logic [WIDTH-1:0] head_data, skid_data;
    logic [SEL_W-1:0] head_sel, skid_sel;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;
    logic             accept, pop;

    // Source mux; any index with no matching source falls through to zero.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i))
                sel_word = src_data[i*WIDTH +: WIDTH];
        end
    end

    assign sel_oor = ({1'b0, sel} >= (SEL_W+1)'(NUM_SRC));

    // in_ready depends only on the state register (plus reset), never on
    // out_ready or in_valid, so the upstream ready path stays short.
    assign in_ready  = !reset && (state != S_TWO);
    assign out_valid = (state != S_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head_data;
    assign out_sel   = head_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            head_data <= '0;
            head_sel  <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        head_data <= sel_word;
                        head_sel  <= sel;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && pop) begin
                        head_data <= sel_word;
                        head_sel  <= sel;
                    end else if (accept) begin
                        skid_data <= sel_word;
                        skid_sel  <= sel;
                        state     <= S_TWO;
                    end else if (pop) begin
                        state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Full: in_ready is low, so only a pop can happen here.
                    if (pop) begin
                        head_data <= skid_data;
                        head_sel  <= skid_sel;
                        state     <= S_ONE;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Sticky error; a new out-of-range accept beats a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_sel <= 1'b0;
        else if (accept && sel_oor)
            err_sel <= 1'b1;
        else if (err_clr)
            err_sel <= 1'b0;
    end

`ifdef OPSEL_XFER_COUNT_EN
    logic [15:0] xfer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            xfer_q <= '0;
        else if (pop)
            xfer_q <= xfer_q + 16'd1;
    end

    assign xfer_count = xfer_q;
`else
    assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Scoreboard bench for operand_sel_pipe. Instance a uses 4 sources (scoreboard
// checked), instance b uses 3 sources to exercise the out-of-range path.
module tb_operand_sel_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_err_clr;
    logic [1:0]   a_sel, a_out_sel;
    logic [127:0] a_src;
    logic [31:0]  a_out_data;
    logic [15:0]  a_xfer;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_err_clr;
    logic [1:0]   b_sel, b_out_sel;
    logic [95:0]  b_src;
    logic [31:0]  b_out_data;
    logic [15:0]  b_xfer;

    operand_sel_pipe #(.WIDTH(32), .NUM_SRC(4), .SEL_W(2)) dut_a (
        .clk(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .src_data(a_src), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_sel(a_out_sel), .err_sel(a_err), .err_clr(a_err_clr),
        .xfer_count(a_xfer)
    );

    operand_sel_pipe #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) dut_b (
        .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .src_data(b_src), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_sel(b_out_sel), .err_sel(b_err), .err_clr(b_err_clr),
        .xfer_count(b_xfer)
    );

    logic [31:0] src_v [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    beat_t q[$];
    beat_t mon_e;
    int    n_cmp = 0;
    int    n_err = 0;
    int    pops  = 0;
    int    pops0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop/compare on delivery, then push on accept (inputs are
    // stable at the falling edge since they only change 1 unit after rising).
    always @(negedge clk) begin
        if (!rst) begin
            if (a_out_valid && a_out_ready) begin
                pops++;
                if (q.size() == 0) begin
                    chk("sb_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("sb_data", a_out_data, mon_e.d);
                    chk("sb_sel", {30'd0, a_out_sel}, {30'd0, mon_e.s});
                end
            end
            if (a_in_valid && a_in_ready)
                q.push_back('{d: src_v[a_sel], s: a_sel});
        end
    end

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_err_clr = 0; a_sel = 0;
        b_in_valid = 0; b_out_ready = 0; b_err_clr = 0; b_sel = 0;
        a_src = {src_v[3], src_v[2], src_v[1], src_v[0]};
        b_src = {src_v[2], src_v[1], src_v[0]};
        step();
        step();

        // Reset state
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_err", a_err, 0);
        chk("rst_xfer", a_xfer, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", a_in_ready, 1);

        // Basic select
        a_out_ready = 1; a_in_valid = 1; a_sel = 2;
        step();
        a_in_valid = 0;
        chk("basic_valid", a_out_valid, 1);
        chk("basic_data", a_out_data, 32'h33333333);
        chk("basic_sel", a_out_sel, 2);
        step();
        chk("basic_drain", a_out_valid, 0);

        // Backpressure / skid
        a_out_ready = 0; a_in_valid = 1; a_sel = 0;
        step();
        a_sel = 1;
        chk("skid_ready_one", a_in_ready, 1);
        step();
        a_in_valid = 0;
        chk("skid_ready_two", a_in_ready, 0);
        chk("skid_head", a_out_data, 32'h11111111);
        step();
        chk("skid_stable_data", a_out_data, 32'h11111111);
        chk("skid_stable_sel", a_out_sel, 0);
        chk("skid_still_full", a_in_ready, 0);
        a_out_ready = 1;
        step();
        chk("skid_ready_back", a_in_ready, 1);
        chk("skid_second", a_out_data, 32'h22222222);
        step();
        chk("skid_drain", a_out_valid, 0);

        // Out-of-range on the 3-source instance
        b_out_ready = 1; b_in_valid = 1; b_sel = 3;
        step();
        b_in_valid = 0;
        chk("oor_valid", b_out_valid, 1);
        chk("oor_data", b_out_data, 0);
        chk("oor_sel", b_out_sel, 3);
        chk("oor_err", b_err, 1);
        step();
        chk("oor_err_held", b_err, 1);
        b_err_clr = 1;
        step();
        b_err_clr = 0;
        chk("oor_err_clr", b_err, 0);
        b_in_valid = 1; b_sel = 2;
        step();
        chk("b_inrange_data", b_out_data, 32'h33333333);
        chk("b_inrange_noerr", b_err, 0);
        b_sel = 3; b_err_clr = 1;
        step();
        b_in_valid = 0; b_err_clr = 0;
        chk("oor_set_wins", b_err, 1);

        // Streaming, 100 beats at one per cycle
        pops0 = pops;
        a_out_ready = 1;
        for (int i = 0; i < 100; i++) begin
            a_in_valid = 1; a_sel = 2'(i % 4);
            chk("stream_in_ready", a_in_ready, 1);
            step();
            chk("stream_out_valid", a_out_valid, 1);
        end
        a_in_valid = 0;
        step();
        chk("stream_pops", pops - pops0, 100);
        chk("stream_sb_empty", q.size(), 0);
`ifdef OPSEL_XFER_COUNT_EN
        chk("stream_xfer", a_xfer, 103);
`else
        chk("stream_xfer", a_xfer, 0);
`endif

        // Reset mid-operation with two beats buffered and err_sel set on b
        a_out_ready = 0; a_in_valid = 1; a_sel = 0;
        step();
        a_sel = 3;
        step();
        a_in_valid = 0;
        chk("pre_rst_full", a_in_ready, 0);
        chk("pre_rst_b_err", b_err, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", a_out_valid, 0);
        chk("midrst_data", a_out_data, 0);
        chk("midrst_sel", a_out_sel, 0);
        chk("midrst_in_ready", a_in_ready, 0);
        chk("midrst_b_err", b_err, 0);
        chk("midrst_xfer", a_xfer, 0);
        q.delete();
        step();
        rst = 1'b0;
        a_out_ready = 1; a_in_valid = 1; a_sel = 1;
        step();
        a_in_valid = 0;
        chk("postrst_data", a_out_data, 32'h22222222);
        chk("postrst_sel", a_out_sel, 1);
        step();
        chk("postrst_drain", a_out_valid, 0);

`ifdef OPSEL_XFER_COUNT_EN
        // Counter wrap: one pop since reset, add 65534 for 0xFFFF, then one more
        for (int i = 0; i < 65534; i++) begin
            a_in_valid = 1; a_sel = 2'(i % 4);
            step();
        end
        a_in_valid = 0;
        step();
        chk("wrap_ffff", a_xfer, 32'h0000FFFF);
        a_in_valid = 1; a_sel = 3;
        step();
        a_in_valid = 0;
        step();
        chk("wrap_zero", a_xfer, 0);
`else
        chk("no_counter_xfer", a_xfer, 0);
`endif

        chk("final_sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
